spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

Byte-level command decoder and register file that sits directly downstream of the SPI slave receiver. It consumes each received word (`rdata` plus its one-cycle `done` strobe) and produces the next word the slave shifts out on MISO (`wdata`). Using the slave's frame boundary (NSS), it turns an SPI frame into a burst read or write of an internal register bank with auto-incrementing address. It exports the register bank to the rest of the FPGA.

## Interface
- `BIT_WIDTH`, 8 — word width; must match the slave's; ≥ 4.
- `REG_NUM`, 16 — number of registers; 2 ≤ REG_NUM ≤ 2^(BIT_WIDTH-1).
- `DEV_ID`, 8'h5A — read-only content of register 0.
- Reset values are 0 for registers 1..REG_NUM-1.
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` in 1 — system clock, same as the slave's.
- `rst_n` in 1 — asynchronous active-low reset.
- `nss` in 1 — raw SPI chip select, active low; synchronised internally with a 2-flop synchroniser.
- `done` in 1 — slave word-complete strobe, one cycle.
- `rdata` in BIT_WIDTH — slave received word, valid while `done`=1.
- `wdata` out BIT_WIDTH — next word for the slave to transmit.
- `reg_q` out REG_NUM*BIT_WIDTH — flattened register bank; reg i is at bits [i*BIT_WIDTH +: BIT_WIDTH].
- `wr_stb` out 1 — one-cycle pulse per accepted register write.
- `wr_addr` out BIT_WIDTH-1 — address of the write flagged by `wr_stb`.
- `err` out 1 — one-cycle pulse on an illegal access.

## Operation
- Frame format: word 0 is the command `{rw, addr[BIT_WIDTH-2:0]}`, where rw=1 is a read and rw=0 is a write. Words 1..N are data.
- States: IDLE, CMD, WR, RD.
  - IDLE→CMD on synchronised NSS falling edge.
  - CMD→RD on `done` with rw=1.
  - CMD→WR on `done` with rw=0.
  - Any state→IDLE when synchronised NSS is high.
- Command accept (`done` in CMD):
  - Latch `addr` into the pointer.
  - Clear `err_sticky`.
  - For a read, load `wdata` with reg[addr] and increment the pointer.
- WR, on `done`:
  - Write `rdata` to reg[ptr]; pulse `wr_stb` with `wr_addr`=ptr.
  - Increment the pointer.
- RD, on `done`:
  - Load `wdata` with reg[ptr]; increment the pointer.
  - `rdata` is ignored.
- Pointer wraps REG_NUM-1 → 0.
- Illegal accesses:
  - Address ≥ REG_NUM: a read returns 0 and a write is dropped. Both pulse `err` and set `err_sticky`.
  - Write to register 0: dropped, `err` pulse, `err_sticky` set, no `wr_stb`.
- Status word: in IDLE and CMD, `wdata` = `{err_sticky, 0…, 1'b1}`, so the master receives status during the command word.
- In WR, `wdata` holds the status word.
- Frame abort (NSS rises mid-word): no `done` arrives, so nothing is written. Return to IDLE; registers keep their values.

## Timing
- Reset values:
  - `wdata` = status with `err_sticky`=0, i.e. {0…,1}.
  - `wr_stb`=0, `err`=0, `wr_addr`=0.
  - `reg_q`: reg0 = DEV_ID, all others 0.
  - State is IDLE.
- Latency: `wdata`, `wr_stb`, `err` and the register update are all registered on the `clk` edge at which `done`=1. They are visible one cycle after `done`. This meets the slave, which samples `wdata` one cycle after `done`.
- NSS falling to CMD takes 3 cycles (2 sync + edge detect). `wdata` is already stable from IDLE, so the slave's frame-start sample sees the status word.
- `done` coincident with NSS-high detection: the `done` action completes first, then the block goes to IDLE.
- `done` in IDLE is ignored.
- Reset mid-frame: immediate return to reset values; register contents are lost.

## Structure
- Package `spi_reg_pkg` holds:
  - State enum `state_t`.
  - `RW_BIT` position.
  - `STAT_OK_BIT`=0 and `STAT_ERR_BIT`=BIT_WIDTH-1 constants.
- Sub-module `spi_reg_file`:
  - Inputs: write enable, write address, write data, read address.
  - Output: combinational read data and flattened `reg_q`.
  - Enforces the reg-0 read-only and range checks.
- The top level holds the synchroniser, the FSM, the pointer and the status logic.

## Test plan
- Reset, then read frame cmd 8'h80 plus 1 dummy word: master receives 8'h01, then 8'h5A (DEV_ID).
- Write frame 8'h03, 8'h11, 8'h22: reg3=8'h11 and reg4=8'h22; two `wr_stb` pulses with `wr_addr` 3 then 4. A following read 8'h83 with 2 words returns 8'h11, 8'h22.
- Wrap: write 8'h0F, 8'hAA, 8'hBB with REG_NUM=16: reg15=8'hAA; the write to reg0 is dropped with an `err` pulse and reg0 stays 8'h5A. The next frame's status word is 8'h81.
- Out of range: read 8'h90 gives data 8'h00 and an `err` pulse. The next frame's status is 8'h81; the status in the frame after that is 8'h01.
- Abort: write 8'h05, then NSS rises after 4 bits of the data word: reg5 unchanged, no `wr_stb`, state IDLE. A new frame works normally.
- `rst_n` low mid-read-burst: outputs return to reset values, reg3 returns to 0, `wdata`=8'h01.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and bit positions for the SPI command decoder / register bank.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WR   = 2'd2,
      RD   = 2'd3
   } state_t;

   localparam int STAT_OK_BIT = 0;

   // Read/write flag sits in the MSB of the command word.
   function automatic int rw_bit(input int bit_width);
      return bit_width - 1;
   endfunction

   function automatic int stat_err_bit(input int bit_width);
      return bit_width - 1;
   endfunction

   function automatic logic in_range(input int addr, input int reg_num);
      return (addr < reg_num);
   endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Word-level handshake between the SPI slave receiver and the register bridge.
interface spi_reg_bridge_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 nss;
   logic                 done;
   logic [BIT_WIDTH-1:0] rdata;
   logic [BIT_WIDTH-1:0] wdata;

   modport slave (input nss, input done, input rdata, output wdata);
   modport master (output nss, output done, output rdata, input wdata);
endinterface

// File: rtl/spi_reg_file.sv
// Register bank: reg 0 is a read-only ID, out-of-range reads return zero and
// illegal writes are dropped; bad-access flags are reported combinationally.
module spi_reg_file
   import spi_reg_pkg::*;
#(
   parameter int                   BIT_WIDTH = 8,
   parameter int                   REG_NUM   = 16,
   parameter logic [BIT_WIDTH-1:0] DEV_ID    = 8'h5A
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we_i,
   input  logic [BIT_WIDTH-2:0]         waddr_i,
   input  logic [BIT_WIDTH-1:0]         wdata_i,
   input  logic [BIT_WIDTH-2:0]         raddr_i,
   output logic [BIT_WIDTH-1:0]         rdata_o,
   output logic                         wr_bad_o,
   output logic                         rd_bad_o,
   output logic [REG_NUM*BIT_WIDTH-1:0] reg_q_o
);
   localparam int AW = BIT_WIDTH - 1;

   logic [BIT_WIDTH-1:0] regs_q [1:REG_NUM-1];
   logic                 wr_ok_s;

   assign wr_bad_o = (waddr_i == {AW{1'b0}}) || !in_range(int'(waddr_i), REG_NUM);
   assign rd_bad_o = !in_range(int'(raddr_i), REG_NUM);
   assign wr_ok_s  = we_i && !wr_bad_o;

   // writable registers 1..REG_NUM-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < REG_NUM; i++) regs_q[i] <= {BIT_WIDTH{1'b0}};
      end else if (wr_ok_s) begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (waddr_i == AW'(i)) regs_q[i] <= wdata_i;
         end
      end
   end

   // read mux; unmatched (out-of-range) addresses fall through to zero
   always_comb begin
      rdata_o = {BIT_WIDTH{1'b0}};
      if (raddr_i == {AW{1'b0}}) begin
         rdata_o = DEV_ID;
      end else begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (raddr_i == AW'(i)) rdata_o = regs_q[i];
         end
      end
   end

   // flattened export of the bank
   always_comb begin
      reg_q_o = {(REG_NUM*BIT_WIDTH){1'b0}};
      reg_q_o[0 +: BIT_WIDTH] = DEV_ID;
      for (int i = 1; i < REG_NUM; i++) reg_q_o[i*BIT_WIDTH +: BIT_WIDTH] = regs_q[i];
   end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns SPI frames (command word + data words) into auto-incrementing burst
// reads/writes of the register bank and supplies the next MISO word.
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int                   BIT_WIDTH = 8,
   parameter int                   REG_NUM   = 16,
   parameter logic [BIT_WIDTH-1:0] DEV_ID    = 8'h5A
) (
   input  logic                         clk,
   input  logic                         rst_n,
   spi_reg_bridge_if.slave              bus,
   output logic [REG_NUM*BIT_WIDTH-1:0] reg_q,
   output logic                         wr_stb,
   output logic [BIT_WIDTH-2:0]         wr_addr,
   output logic                         err
);
   localparam int AW           = BIT_WIDTH - 1;
   localparam int RW_BIT       = rw_bit(BIT_WIDTH);
   localparam int STAT_ERR_BIT = stat_err_bit(BIT_WIDTH);

   state_t               state_q, state_d;
   logic                 nss_s1_q, nss_s2_q, nss_prev_q;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic                 sticky_q, sticky_d;
   logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
   logic                 wr_stb_q, wr_stb_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic                 err_q, err_d;

   logic                 nss_fall_s;
   logic                 we_s;
   logic [AW-1:0]        raddr_s;
   logic [AW-1:0]        cmd_addr_s;
   logic [BIT_WIDTH-1:0] rd_data_s;
   logic                 wr_bad_s, rd_bad_s;

   function automatic logic [BIT_WIDTH-1:0] status_word(input logic sticky);
      logic [BIT_WIDTH-1:0] w;
      w               = {BIT_WIDTH{1'b0}};
      w[STAT_OK_BIT]  = 1'b1;
      w[STAT_ERR_BIT] = sticky;
      return w;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(REG_NUM - 1)) ? {AW{1'b0}} : p + AW'(1);
   endfunction

   assign nss_fall_s = nss_prev_q && !nss_s2_q;
   assign cmd_addr_s = bus.rdata[AW-1:0];

   spi_reg_file #(
      .BIT_WIDTH (BIT_WIDTH),
      .REG_NUM   (REG_NUM),
      .DEV_ID    (DEV_ID)
   ) u_file (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (we_s),
      .waddr_i  (ptr_q),
      .wdata_i  (bus.rdata),
      .raddr_i  (raddr_s),
      .rdata_o  (rd_data_s),
      .wr_bad_o (wr_bad_s),
      .rd_bad_o (rd_bad_s),
      .reg_q_o  (reg_q)
   );

   // synchroniser, FSM state and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nss_s1_q   <= 1'b1;
         nss_s2_q   <= 1'b1;
         nss_prev_q <= 1'b1;
         state_q    <= IDLE;
         ptr_q      <= {AW{1'b0}};
         sticky_q   <= 1'b0;
         wdata_q    <= status_word(1'b0);
         wr_stb_q   <= 1'b0;
         wr_addr_q  <= {AW{1'b0}};
         err_q      <= 1'b0;
      end else begin
         nss_s1_q   <= bus.nss;
         nss_s2_q   <= nss_s1_q;
         nss_prev_q <= nss_s2_q;
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sticky_q   <= sticky_d;
         wdata_q    <= wdata_d;
         wr_stb_q   <= wr_stb_d;
         wr_addr_q  <= wr_addr_d;
         err_q      <= err_d;
      end
   end

   // next-state, pointer and status decode
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sticky_d  = sticky_q;
      wdata_d   = wdata_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      err_d     = 1'b0;
      we_s      = 1'b0;
      raddr_s   = ptr_q;

      case (state_q)
         IDLE: begin
            if (nss_fall_s) state_d = CMD;
            else            state_d = IDLE;
         end
         CMD: begin
            if (bus.done) begin
               ptr_d    = cmd_addr_s;
               sticky_d = 1'b0;
               if (bus.rdata[RW_BIT]) begin
                  raddr_s = cmd_addr_s;
                  wdata_d = rd_data_s;
                  ptr_d   = ptr_inc(cmd_addr_s);
                  state_d = RD;
                  if (rd_bad_s) begin
                     err_d    = 1'b1;
                     sticky_d = 1'b1;
                  end else begin
                     err_d = 1'b0;
                  end
               end else begin
                  state_d = WR;
               end
            end else begin
               state_d = CMD;
            end
         end
         WR: begin
            if (bus.done) begin
               we_s  = 1'b1;
               ptr_d = ptr_inc(ptr_q);
               if (wr_bad_s) begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
               end else begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
               end
            end else begin
               state_d = WR;
            end
         end
         RD: begin
            if (bus.done) begin
               wdata_d = rd_data_s;
               ptr_d   = ptr_inc(ptr_q);
               if (rd_bad_s) begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
               end else begin
                  err_d = 1'b0;
               end
            end else begin
               state_d = RD;
            end
         end
         default: state_d = IDLE;
      endcase

      // a word completing together with NSS release is still serviced above
      if (nss_s2_q) state_d = IDLE;
      else          state_d = state_d;

      if (state_d != RD) wdata_d = status_word(sticky_d);
      else               wdata_d = wdata_d;
   end

   assign bus.wdata = wdata_q;
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed table-driven bench for spi_reg_bridge acting as the SPI slave's word stream.
module tb_spi_reg_bridge;
   import spi_reg_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] reg_q;
   logic         wr_stb;
   logic [6:0]   wr_addr;
   logic         err;
   int           total = 0;
   int           bad = 0;
   int           stb_cnt = 0;

   always #5 clk = ~clk;

   spi_reg_bridge_if #(.BIT_WIDTH(8)) bus ();

   spi_reg_bridge #(
      .BIT_WIDTH (8),
      .REG_NUM   (16),
      .DEV_ID    (8'h5A)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .reg_q   (reg_q),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .err     (err)
   );

   always @(negedge clk) if (wr_stb) stb_cnt++;

   typedef struct {
      logic       sof;
      logic       eof;
      logic [7:0] mosi;
      logic [7:0] miso;
      logic       stb;
      logic [6:0] waddr;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic sof, input logic eof, input logic [7:0] mosi,
                               input logic [7:0] miso, input logic stb, input logic [6:0] waddr,
                               input logic er);
      vec_t v;
      v.sof = sof; v.eof = eof; v.mosi = mosi; v.miso = miso;
      v.stb = stb; v.waddr = waddr; v.er = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      bus.nss = 1'b0;
      repeat (4) tick();
   endtask

   task automatic frame_end();
      bus.nss = 1'b1;
      repeat (4) tick();
   endtask

   function automatic logic [7:0] rg(input int i);
      return reg_q[i*8 +: 8];
   endfunction

   task automatic xfer(input string name, input logic [7:0] mosi, input logic [7:0] miso,
                       input logic stb, input logic [6:0] waddr, input logic er);
      check({name, "_miso"}, bus.wdata, miso);
      bus.done  = 1'b1;
      bus.rdata = mosi;
      tick();
      bus.done  = 1'b0;
      bus.rdata = 8'h00;
      check({name, "_stb"}, wr_stb, stb);
      check({name, "_err"}, err, er);
      if (stb) check({name, "_waddr"}, wr_addr, waddr);
      repeat (3) tick();
      check({name, "_pulse_end"}, {wr_stb, err}, 2'b00);
   endtask

   initial begin
      int cnt0;
      bus.nss   = 1'b1;
      bus.done  = 1'b0;
      bus.rdata = 8'h00;

      vecs.push_back(mk(1'b1, 1'b0, 8'h80, 8'h01, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 8'h03, 8'h01, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 8'h11, 8'h01, 1'b1, 7'd3,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h22, 8'h01, 1'b1, 7'd4,  1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 8'h83, 8'h01, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 8'h0F, 8'h01, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 8'hAA, 8'h01, 1'b1, 7'd15, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'hBB, 8'h01, 1'b0, 7'd0,  1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 8'h80, 8'h81, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 8'h90, 8'h01, 1'b0, 7'd0,  1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 7'd0,  1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 8'h84, 8'h81, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 8'h83, 8'h01, 1'b0, 7'd0,  1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 7'd0,  1'b0));

      repeat (3) tick();
      check("rst_wdata", bus.wdata, 8'h01);
      check("rst_reg0", rg(0), 8'h5A);
      check("rst_reg3", rg(3), 8'h00);
      check("rst_outs", {wr_stb, err, wr_addr}, 9'h000);
      rst_n = 1'b1;
      repeat (2) tick();

      foreach (vecs[i]) begin
         if (vecs[i].sof) frame_start();
         xfer($sformatf("v%0d", i), vecs[i].mosi, vecs[i].miso, vecs[i].stb,
              vecs[i].waddr, vecs[i].er);
         if (vecs[i].eof) frame_end();
      end

      check("bank_reg0", rg(0), 8'h5A);
      check("bank_reg1", rg(1), 8'h00);
      check("bank_reg3", rg(3), 8'h11);
      check("bank_reg4", rg(4), 8'h22);
      check("bank_reg15", rg(15), 8'hAA);

      // abort in the middle of the first data word
      frame_start();
      xfer("abort_cmd", 8'h05, 8'h01, 1'b0, 7'd0, 1'b0);
      repeat (4) tick();
      cnt0 = stb_cnt;
      bus.nss = 1'b1;
      repeat (5) tick();
      check("abort_reg5", rg(5), 8'h00);
      check("abort_nostb", stb_cnt, cnt0);
      check("abort_idle", dut.state_q, IDLE);
      check("abort_wdata", bus.wdata, 8'h01);
      frame_start();
      xfer("post_cmd", 8'h05, 8'h01, 1'b0, 7'd0, 1'b0);
      xfer("post_dat", 8'h77, 8'h01, 1'b1, 7'd5, 1'b0);
      frame_end();
      check("post_reg5", rg(5), 8'h77);

      // done with NSS high must be ignored
      bus.done  = 1'b1;
      bus.rdata = 8'h06;
      tick();
      bus.done  = 1'b0;
      bus.rdata = 8'h00;
      check("idle_done_outs", {wr_stb, err}, 2'b00);
      check("idle_done_state", dut.state_q, IDLE);
      tick();
      check("idle_done_reg6", rg(6), 8'h00);

      // reset in the middle of a read burst
      frame_start();
      xfer("rb_cmd", 8'h83, 8'h01, 1'b0, 7'd0, 1'b0);
      xfer("rb_d0", 8'h00, 8'h11, 1'b0, 7'd0, 1'b0);
      check("rb_pre_wdata", bus.wdata, 8'h22);
      #2 rst_n = 1'b0;
      #1;
      check("rb_wdata", bus.wdata, 8'h01);
      check("rb_reg3", rg(3), 8'h00);
      check("rb_reg0", rg(0), 8'h5A);
      check("rb_outs", {wr_stb, err, wr_addr}, 9'h000);
      check("rb_state", dut.state_q, IDLE);
      bus.nss = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
